// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory responder / program loader.
package prog_loader_pkg;

    localparam int DEFAULT_DEPTH = 128;
    localparam int DEFAULT_AW    = 7;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;

    // state     | meaning
    // RELEASE   | core held in reset, release counter running
    // RUN       | core running, fetches served from the array
    // HI        | loading, waiting for the high nibble of a byte
    // LO        | loading, waiting for the low nibble; writes the byte
    typedef logic [1:0] state_t;
    localparam state_t ST_RELEASE = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_HI      = 2'd2;
    localparam state_t ST_LO      = 2'd3;

endpackage

// File: rtl/imem_array.sv
// Instruction byte array: one synchronous write port, one asynchronous read port.
// No reset path; contents survive core and loader resets.
module imem_array
    import prog_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output byte_t         rdata
);

    byte_t mem [DEPTH];

    // Byte write from the loader, visible on the read port the following cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader_mem.sv
// Fetch responder and nibble-stream program loader for the 4-bit core.
// Holds the core in reset while loading and for RELEASE_CYCLES afterwards.
module prog_loader_mem
    import prog_loader_pkg::*;
#(
    parameter int DEPTH          = DEFAULT_DEPTH,
    parameter int AW             = DEFAULT_AW,
    parameter int RELEASE_CYCLES = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc,
    output logic [7:0]    instr,
    output logic          core_rstn,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [3:0]    ld_nibble,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          load_busy,
    output logic [7:0]    load_count,
    output logic          ovf
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [7:0]    REL_LAST  = 8'(RELEASE_CYCLES - 1);

    state_t        state;
    state_t        state_next;
    logic [7:0]    rel_cnt;
    logic [AW-1:0] addr;
    nibble_t       hi_nib;
    logic          xfer;
    logic          at_end;
    logic          we;

    assign xfer   = ld_valid & ld_ready;
    assign at_end = (addr == LAST_ADDR);
    assign we     = (state == ST_LO) && xfer;

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .we    (we),
        .waddr (addr),
        .wdata ({hi_nib, ld_nibble}),
        .raddr (pc),
        .rdata (instr)
    );

    // Next-state decode; a load ends on LD_LAST or when the last address is written.
    always_comb begin
        state_next = state;
        case (state)
            ST_RELEASE: if (rel_cnt == REL_LAST) state_next = ST_RUN;
            ST_RUN:     if (load_start)          state_next = ST_HI;
            ST_HI:      if (xfer)                state_next = ST_LO;
            ST_LO: begin
                if (xfer) begin
                    state_next = (ld_last || at_end) ? ST_RELEASE : ST_HI;
                end
            end
            default:                             state_next = ST_RELEASE;
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RELEASE;
            rel_cnt    <= 8'd0;
            addr       <= '0;
            load_count <= 8'd0;
            ovf        <= 1'b0;
            hi_nib     <= '0;
            core_rstn  <= 1'b0;
            ld_ready   <= 1'b0;
            load_busy  <= 1'b0;
        end else begin
            state     <= state_next;
            core_rstn <= (state_next == ST_RUN);
            ld_ready  <= (state_next == ST_HI) || (state_next == ST_LO);
            load_busy <= (state_next == ST_HI) || (state_next == ST_LO);
            case (state)
                ST_RELEASE: rel_cnt <= rel_cnt + 8'd1;
                ST_RUN: begin
                    if (load_start) begin
                        addr       <= '0;
                        load_count <= 8'd0;
                        ovf        <= 1'b0;
                    end
                end
                ST_HI: begin
                    if (xfer) hi_nib <= ld_nibble;
                end
                ST_LO: begin
                    if (xfer) begin
                        load_count <= load_count + 8'd1;
                        // Address saturates at the top so it never wraps onto byte 0.
                        if (!at_end) addr <= addr + 1'b1;
                        if (!ld_last && at_end) ovf <= 1'b1;
                        if (ld_last || at_end) rel_cnt <= 8'd0;
                    end
                end
                default: rel_cnt <= 8'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_mem.sv
// Directed bench for prog_loader_mem.
module tb_prog_loader_mem;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] pc = '0;
    logic [7:0] instr;
    logic       core_rstn;
    logic       load_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [3:0] ld_nibble = '0;
    logic       ld_last = 1'b0;
    logic       ld_ready;
    logic       load_busy;
    logic [7:0] load_count;
    logic       ovf;

    int n_vec = 0;
    int n_err = 0;
    int hs_timeouts = 0;

    always #5 clk = ~clk;

    prog_loader_mem #(
        .DEPTH(128), .AW(7), .RELEASE_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .core_rstn(core_rstn),
        .load_start(load_start), .ld_valid(ld_valid), .ld_nibble(ld_nibble),
        .ld_last(ld_last), .ld_ready(ld_ready), .load_busy(load_busy),
        .load_count(load_count), .ovf(ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] n, input logic last, input int gap);
        int k;
        k = 0;
        ld_nibble = n;
        ld_last   = last;
        ld_valid  = 1'b1;
        while (!ld_ready && k < 50) begin
            tick();
            k++;
        end
        if (!ld_ready) hs_timeouts++;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic measure_low(output int lows);
        lows = 0;
        while (core_rstn !== 1'b1 && lows < 40) begin
            lows++;
            tick();
        end
    endtask

    task automatic test_reset();
        int lows;
        rst = 1'b1;
        repeat (3) tick();
        n_vec++; if (core_rstn !== 1'b0) begin n_err++; $display("FAIL rst_core_rstn got %b want 0", core_rstn); end
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL rst_ld_ready got %b want 0", ld_ready); end
        n_vec++; if (load_busy !== 1'b0) begin n_err++; $display("FAIL rst_load_busy got %b want 0", load_busy); end
        n_vec++; if (load_count !== 8'd0) begin n_err++; $display("FAIL rst_load_count got %0d want 0", load_count); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b want 0", ovf); end
        rst = 1'b0;
        measure_low(lows);
        n_vec++; if (lows !== 10) begin n_err++; $display("FAIL rst_release_len got %0d want 10", lows); end
        n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL run_ld_ready got %b want 0", ld_ready); end
    endtask

    task automatic test_overflow();
        int lows;
        logic [7:0] b;
        pulse_start();
        n_vec++; if (load_busy !== 1'b1 || ld_ready !== 1'b1) begin n_err++; $display("FAIL ovf_enter_hi busy/ready got %b%b want 11", load_busy, ld_ready); end
        for (int i = 0; i < 128; i++) begin
            b = 8'(i) ^ 8'hA5;
            send_nib(b[7:4], 1'b0, 0);
            send_nib(b[3:0], 1'b0, 0);
        end
        n_vec++; if (load_count !== 8'd128) begin n_err++; $display("FAIL ovf_count got %0d want 128", load_count); end
        n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf); end
        n_vec++; if (load_busy !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL ovf_release busy/ready got %b%b want 00", load_busy, ld_ready); end
        n_vec++; if (core_rstn !== 1'b0) begin n_err++; $display("FAIL ovf_core_rstn got %b want 0", core_rstn); end
        pc = 7'd0;   #1; n_vec++; if (instr !== 8'hA5) begin n_err++; $display("FAIL ovf_mem0 got %h want a5", instr); end
        pc = 7'd64;  #1; n_vec++; if (instr !== 8'hE5) begin n_err++; $display("FAIL ovf_mem64 got %h want e5", instr); end
        pc = 7'd127; #1; n_vec++; if (instr !== 8'hDA) begin n_err++; $display("FAIL ovf_mem127 got %h want da", instr); end
        measure_low(lows);
        n_vec++; if (lows !== 10) begin n_err++; $display("FAIL ovf_release_len got %0d want 10", lows); end
        n_vec++; if (hs_timeouts !== 0) begin n_err++; $display("FAIL ovf_handshake timeouts got %0d want 0", hs_timeouts); end
    endtask

    task automatic test_idle_array();
        int lows;
        logic [7:0] e;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        measure_low(lows);
        n_vec++; if (lows !== 10) begin n_err++; $display("FAIL idle_release_len got %0d want 10", lows); end
        n_vec++; if (load_count !== 8'd0) begin n_err++; $display("FAIL idle_count got %0d want 0", load_count); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL idle_ovf got %b want 0", ovf); end
        for (int i = 0; i < 128; i++) begin
            pc = 7'(i);
            e = 8'(i) ^ 8'hA5;
            #1;
            n_vec++; if (instr !== e) begin n_err++; $display("FAIL idle_instr pc=%0d got %h want %h", i, instr, e); end
        end
    endtask

    task automatic test_basic_load();
        int lows;
        pulse_start();
        n_vec++; if (core_rstn !== 1'b0) begin n_err++; $display("FAIL basic_core_rstn got %b want 0", core_rstn); end
        n_vec++; if (load_count !== 8'd0) begin n_err++; $display("FAIL basic_count_clear got %0d want 0", load_count); end
        send_nib(4'h3, 1'b0, 0);
        send_nib(4'hA, 1'b0, 0);
        send_nib(4'h5, 1'b0, 0);
        send_nib(4'hC, 1'b1, 0);
        n_vec++; if (load_count !== 8'd2) begin n_err++; $display("FAIL basic_count got %0d want 2", load_count); end
        n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b want 0", ovf); end
        n_vec++; if (load_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy got %b want 0", load_busy); end
        measure_low(lows);
        n_vec++; if (lows !== 10) begin n_err++; $display("FAIL basic_release_len got %0d want 10", lows); end
        pc = 7'd0; #1; n_vec++; if (instr !== 8'h3A) begin n_err++; $display("FAIL basic_mem0 got %h want 3a", instr); end
        pc = 7'd1; #1; n_vec++; if (instr !== 8'h5C) begin n_err++; $display("FAIL basic_mem1 got %h want 5c", instr); end
        pc = 7'd2; #1; n_vec++; if (instr !== 8'hA7) begin n_err++; $display("FAIL basic_mem2 got %h want a7", instr); end
    endtask

    task automatic test_gaps();
        int lows;
        pulse_start();
        send_nib(4'h3, 1'b0, 2);
        n_vec++; if (ld_ready !== 1'b1 || load_count !== 8'd0) begin n_err++; $display("FAIL gap_mid_hi ready=%b count=%0d want 1,0", ld_ready, load_count); end
        send_nib(4'hA, 1'b0, 2);
        n_vec++; if (load_count !== 8'd1) begin n_err++; $display("FAIL gap_count1 got %0d want 1", load_count); end
        send_nib(4'h5, 1'b0, 2);
        n_vec++; if (load_count !== 8'd1) begin n_err++; $display("FAIL gap_count_hold got %0d want 1", load_count); end
        send_nib(4'hC, 1'b1, 0);
        n_vec++; if (load_count !== 8'd2) begin n_err++; $display("FAIL gap_count got %0d want 2", load_count); end
        measure_low(lows);
        n_vec++; if (lows !== 10) begin n_err++; $display("FAIL gap_release_len got %0d want 10", lows); end
        pc = 7'd0; #1; n_vec++; if (instr !== 8'h3A) begin n_err++; $display("FAIL gap_mem0 got %h want 3a", instr); end
        pc = 7'd1; #1; n_vec++; if (instr !== 8'h5C) begin n_err++; $display("FAIL gap_mem1 got %h want 5c", instr); end
        pc = 7'd2; #1; n_vec++; if (instr !== 8'hA7) begin n_err++; $display("FAIL gap_mem2 got %h want a7", instr); end
    endtask

    task automatic test_midload_reset();
        int lows;
        pulse_start();
        send_nib(4'h1, 1'b0, 0);
        send_nib(4'h2, 1'b0, 0);
        send_nib(4'h4, 1'b0, 0);
        n_vec++; if (load_count !== 8'd1) begin n_err++; $display("FAIL mid_count_pre got %0d want 1", load_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (load_count !== 8'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", load_count); end
        n_vec++; if (load_busy !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL mid_busy_ready got %b%b want 00", load_busy, ld_ready); end
        measure_low(lows);
        n_vec++; if (lows !== 10) begin n_err++; $display("FAIL mid_release_len got %0d want 10", lows); end
        pc = 7'd0; #1; n_vec++; if (instr !== 8'h12) begin n_err++; $display("FAIL mid_mem0 got %h want 12", instr); end
        pc = 7'd1; #1; n_vec++; if (instr !== 8'h5C) begin n_err++; $display("FAIL mid_mem1 got %h want 5c", instr); end
    endtask

    task automatic test_ignored_start();
        int lows;
        pulse_start();
        send_nib(4'h6, 1'b0, 0);
        send_nib(4'h7, 1'b0, 0);
        pulse_start();
        n_vec++; if (load_count !== 8'd1) begin n_err++; $display("FAIL ign_hi_count got %0d want 1", load_count); end
        n_vec++; if (load_busy !== 1'b1 || ld_ready !== 1'b1) begin n_err++; $display("FAIL ign_hi_state busy/ready got %b%b want 11", load_busy, ld_ready); end
        send_nib(4'h8, 1'b0, 0);
        send_nib(4'h9, 1'b1, 0);
        n_vec++; if (load_count !== 8'd2) begin n_err++; $display("FAIL ign_count got %0d want 2", load_count); end
        pulse_start();
        n_vec++; if (load_busy !== 1'b0 || ld_ready !== 1'b0) begin n_err++; $display("FAIL ign_rel_state busy/ready got %b%b want 00", load_busy, ld_ready); end
        n_vec++; if (load_count !== 8'd2) begin n_err++; $display("FAIL ign_rel_count got %0d want 2", load_count); end
        measure_low(lows);
        n_vec++; if (lows !== 9) begin n_err++; $display("FAIL ign_release_len got %0d want 9", lows); end
        pc = 7'd0; #1; n_vec++; if (instr !== 8'h67) begin n_err++; $display("FAIL ign_mem0 got %h want 67", instr); end
        pc = 7'd1; #1; n_vec++; if (instr !== 8'h89) begin n_err++; $display("FAIL ign_mem1 got %h want 89", instr); end
        n_vec++; if (hs_timeouts !== 0) begin n_err++; $display("FAIL ign_handshake timeouts got %0d want 0", hs_timeouts); end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_idle_array();
        test_basic_load();
        test_gaps();
        test_midload_reset();
        test_ignored_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
